// File: rtl/mwc_pkg.sv
// Shared encodings for the memory-write checker: FSM state codes and failure codes.
package mwc_pkg;

    localparam int unsigned ST_W = 2;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_PASS = 2'd2;
    localparam state_t ST_FAIL = 2'd3;

    localparam int unsigned FC_W = 3;
    typedef logic [FC_W-1:0] fail_code_t;

    localparam fail_code_t FC_NONE    = 3'd0;
    localparam fail_code_t FC_DATA    = 3'd1;
    localparam fail_code_t FC_ADDR    = 3'd2;
    localparam fail_code_t FC_TIMEOUT = 3'd3;
    localparam fail_code_t FC_DUP     = 3'd4;

endpackage

// File: rtl/mwc_match.sv
// N-way address compare against the loaded table with a lowest-index priority
// encoder; also reports whether the winning entry's data equals the probe data.
//   i_tbl_addr / i_tbl_data : expected table
//   i_valid                 : per-entry loaded flag
//   i_addr / i_data         : observed write
//   o_any_match_c           : some loaded entry has i_addr
//   o_match_idx_c           : lowest matching index (0 when none)
//   o_data_eq_c             : data of entry o_match_idx_c equals i_data
module mwc_match #(
    parameter int unsigned N      = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 3
) (
    input  logic [N-1:0][ADDR_W-1:0] i_tbl_addr,
    input  logic [N-1:0][DATA_W-1:0] i_tbl_data,
    input  logic [N-1:0]             i_valid,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [DATA_W-1:0]        i_data,
    output logic                     o_any_match_c,
    output logic [IDX_W-1:0]         o_match_idx_c,
    output logic                     o_data_eq_c
);

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin : prio_enc
        o_any_match_c = 1'b0;
        o_match_idx_c = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_tbl_addr[i] == i_addr)) begin
                o_any_match_c = 1'b1;
                o_match_idx_c = IDX_W'(i);
            end
        end
        o_data_eq_c = (i_tbl_data[o_match_idx_c] == i_data);
    end

endmodule

// File: rtl/mem_write_checker.sv
// Self-checking monitor for the data-memory write port. A table of expected
// (address, data) pairs is loaded in IDLE; after start, snooped writes are
// checked in table order (ORDERED=1) or any order (ORDERED=0), with duplicate,
// unexpected-address and timeout detection.
//   clk, reset (async, active-low)
//   load_valid/load_addr/load_data : append expected entry (IDLE only)
//   start                          : begin/restart checking
//   MemWrite/Adr/WriteData         : snooped core write port
//   done/pass/fail/fail_code/fail_idx/match_count/cycle_count : verdict and progress
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int unsigned  ADDR_W   = 32,
    parameter int unsigned  DATA_W   = 32,
    parameter int unsigned  N_CHECKS = 8,
    parameter int unsigned  TIMEOUT  = 4096,
    parameter bit           ORDERED  = 1'b1,
    localparam int unsigned IDX_W    = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1,
    localparam int unsigned CNT_W    = $clog2(N_CHECKS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Adr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [FC_W-1:0]   fail_code,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [CNT_W-1:0]  match_count,
    output logic [31:0]       cycle_count
);

    localparam int unsigned CC_W = 32;

    state_t                          r_state, w_state_nxt;
    logic [N_CHECKS-1:0][ADDR_W-1:0] r_tbl_addr;
    logic [N_CHECKS-1:0][DATA_W-1:0] r_tbl_data;
    logic [N_CHECKS-1:0]             r_hit, w_hit_nxt, w_valid;
    logic [CNT_W-1:0]                r_load_ptr, w_load_ptr_nxt;
    logic [CNT_W-1:0]                r_match_count, w_match_count_nxt;
    logic [CC_W-1:0]                 r_cycle_count, w_cycle_count_nxt;
    logic [FC_W-1:0]                 r_fail_code, w_fail_code_nxt;
    logic [IDX_W-1:0]                r_fail_idx, w_fail_idx_nxt;
    logic [IDX_W-1:0]                w_exp_idx, w_match_idx;
    logic                            w_load_en, w_any_match, w_data_eq;
    logic                            w_exp_addr_eq, w_exp_data_eq;
    logic                            r_done, r_pass, r_fail;

    // Only entries below the load pointer take part in address matching.
    always_comb begin : valid_mask
        for (int i = 0; i < int'(N_CHECKS); i++) begin
            w_valid[i] = (CNT_W'(i) < r_load_ptr);
        end
    end

    // In-order mode compares against the next unmatched entry.
    assign w_exp_idx     = IDX_W'(r_match_count);
    assign w_exp_addr_eq = w_valid[w_exp_idx] && (r_tbl_addr[w_exp_idx] == Adr);
    assign w_exp_data_eq = (r_tbl_data[w_exp_idx] == WriteData);

    mwc_match #(
        .N      (N_CHECKS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_match (
        .i_tbl_addr    (r_tbl_addr),
        .i_tbl_data    (r_tbl_data),
        .i_valid       (w_valid),
        .i_addr        (Adr),
        .i_data        (WriteData),
        .o_any_match_c (w_any_match),
        .o_match_idx_c (w_match_idx),
        .o_data_eq_c   (w_data_eq)
    );

    // Next-state and datapath update.
    always_comb begin : next_state
        w_state_nxt       = r_state;
        w_hit_nxt         = r_hit;
        w_load_ptr_nxt    = r_load_ptr;
        w_load_en         = 1'b0;
        w_match_count_nxt = r_match_count;
        w_cycle_count_nxt = r_cycle_count;
        w_fail_code_nxt   = r_fail_code;
        w_fail_idx_nxt    = r_fail_idx;

        case (r_state)
            ST_IDLE: begin
                if (load_valid && (r_load_ptr < CNT_W'(N_CHECKS))) begin
                    w_load_en      = 1'b1;
                    w_load_ptr_nxt = r_load_ptr + CNT_W'(1);
                end
                if (start) begin
                    w_state_nxt       = ST_RUN;
                    w_hit_nxt         = '0;
                    w_match_count_nxt = '0;
                    w_cycle_count_nxt = '0;
                end
            end

            ST_RUN: begin
                w_cycle_count_nxt = r_cycle_count + CC_W'(1);
                // A write is only meaningful while entries remain; an empty
                // table goes straight to PASS below.
                if (MemWrite && (r_match_count != r_load_ptr)) begin
                    if (ORDERED) begin
                        if (w_exp_addr_eq) begin
                            if (w_exp_data_eq) begin
                                w_hit_nxt[w_exp_idx] = 1'b1;
                                w_match_count_nxt    = r_match_count + CNT_W'(1);
                            end else begin
                                w_fail_code_nxt = FC_DATA;
                                w_fail_idx_nxt  = w_exp_idx;
                            end
                        end else if (w_any_match && r_hit[w_match_idx]) begin
                            w_fail_code_nxt = FC_DUP;
                            w_fail_idx_nxt  = w_match_idx;
                        end else begin
                            w_fail_code_nxt = FC_ADDR;
                            w_fail_idx_nxt  = '0;
                        end
                    end else begin
                        if (!w_any_match) begin
                            w_fail_code_nxt = FC_ADDR;
                            w_fail_idx_nxt  = '0;
                        end else if (r_hit[w_match_idx]) begin
                            w_fail_code_nxt = FC_DUP;
                            w_fail_idx_nxt  = w_match_idx;
                        end else if (w_data_eq) begin
                            w_hit_nxt[w_match_idx] = 1'b1;
                            w_match_count_nxt      = r_match_count + CNT_W'(1);
                        end else begin
                            w_fail_code_nxt = FC_DATA;
                            w_fail_idx_nxt  = w_match_idx;
                        end
                    end
                end

                // Write outcome takes priority over a coincident timeout.
                if (w_fail_code_nxt != FC_NONE) begin
                    w_state_nxt = ST_FAIL;
                end else if (w_match_count_nxt == r_load_ptr) begin
                    w_state_nxt = ST_PASS;
                end else if (w_cycle_count_nxt == CC_W'(TIMEOUT)) begin
                    w_state_nxt     = ST_FAIL;
                    w_fail_code_nxt = FC_TIMEOUT;
                    w_fail_idx_nxt  = '0;
                end
            end

            ST_PASS, ST_FAIL: begin
                if (start) begin
                    w_state_nxt       = ST_RUN;
                    w_hit_nxt         = '0;
                    w_match_count_nxt = '0;
                    w_cycle_count_nxt = '0;
                    w_fail_code_nxt   = FC_NONE;
                    w_fail_idx_nxt    = '0;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, table and output registers.
    always_ff @(posedge clk or negedge reset) begin : state_reg
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_tbl_addr    <= '0;
            r_tbl_data    <= '0;
            r_hit         <= '0;
            r_load_ptr    <= '0;
            r_match_count <= '0;
            r_cycle_count <= '0;
            r_fail_code   <= FC_NONE;
            r_fail_idx    <= '0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hit         <= w_hit_nxt;
            r_load_ptr    <= w_load_ptr_nxt;
            r_match_count <= w_match_count_nxt;
            r_cycle_count <= w_cycle_count_nxt;
            r_fail_code   <= w_fail_code_nxt;
            r_fail_idx    <= w_fail_idx_nxt;
            r_done        <= (w_state_nxt == ST_PASS) || (w_state_nxt == ST_FAIL);
            r_pass        <= (w_state_nxt == ST_PASS);
            r_fail        <= (w_state_nxt == ST_FAIL);
            if (w_load_en) begin
                r_tbl_addr[IDX_W'(r_load_ptr)] <= load_addr;
                r_tbl_data[IDX_W'(r_load_ptr)] <= load_data;
            end
        end
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign fail_code   = r_fail_code;
    assign fail_idx    = r_fail_idx;
    assign match_count = r_match_count;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: one in-order and one any-order instance share
// stimulus; each is compared against a queue/array-level reference model.
module tb_mem_write_checker;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NC = 8;
    localparam int unsigned TO = 20;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          load_valid, start, mem_write;
    logic [AW-1:0] load_addr, adr;
    logic [DW-1:0] load_data, wdata;

    // index 0: any-order instance, index 1: in-order instance
    logic [1:0]    dn, ps, fl;
    logic [2:0]    fc [2];
    logic [IW-1:0] fi [2];
    logic [CW-1:0] mc [2];
    logic [31:0]   cc [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .N_CHECKS(NC), .TIMEOUT(TO), .ORDERED(1'b0)) u_any (
        .clk(clk), .reset(rst_n), .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .start(start), .MemWrite(mem_write), .Adr(adr), .WriteData(wdata),
        .done(dn[0]), .pass(ps[0]), .fail(fl[0]), .fail_code(fc[0]), .fail_idx(fi[0]),
        .match_count(mc[0]), .cycle_count(cc[0]));

    mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .N_CHECKS(NC), .TIMEOUT(TO), .ORDERED(1'b1)) u_ord (
        .clk(clk), .reset(rst_n), .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .start(start), .MemWrite(mem_write), .Adr(adr), .WriteData(wdata),
        .done(dn[1]), .pass(ps[1]), .fail(fl[1]), .fail_code(fc[1]), .fail_idx(fi[1]),
        .match_count(mc[1]), .cycle_count(cc[1]));

    // ---------------- reference model ----------------
    logic [31:0] t_addr [NC];
    logic [31:0] t_data [NC];
    int          t_n;
    bit          m_run [2], m_pass [2], m_fail [2];
    bit          m_hit [2][NC];
    int          m_mc [2], m_cc [2], m_code [2], m_idx [2];

    function automatic int find_first(logic [31:0] a);
        for (int j = 0; j < t_n; j++) if (t_addr[j] == a) return j;
        return -1;
    endfunction

    task automatic model_reset();
        t_n = 0;
        for (int j = 0; j < int'(NC); j++) begin t_addr[j] = '0; t_data[j] = '0; end
        for (int m = 0; m < 2; m++) begin
            m_run[m] = 0; m_pass[m] = 0; m_fail[m] = 0;
            m_mc[m] = 0; m_cc[m] = 0; m_code[m] = 0; m_idx[m] = 0;
            for (int j = 0; j < int'(NC); j++) m_hit[m][j] = 0;
        end
    endtask

    task automatic model_begin(int m);
        m_run[m] = 1; m_pass[m] = 0; m_fail[m] = 0;
        m_mc[m] = 0; m_cc[m] = 0; m_code[m] = 0; m_idx[m] = 0;
        for (int j = 0; j < int'(NC); j++) m_hit[m][j] = 0;
    endtask

    task automatic model_run(int m);
        int code, idx, j;
        code = 0; idx = 0;
        m_cc[m]++;
        if (m_mc[m] == t_n) begin
            m_run[m] = 0; m_pass[m] = 1;
            return;
        end
        if (mem_write) begin
            j = find_first(adr);
            if (m == 1) begin
                if (t_addr[m_mc[m]] == adr) begin
                    if (t_data[m_mc[m]] == wdata) begin m_hit[m][m_mc[m]] = 1; m_mc[m]++; end
                    else begin code = 1; idx = m_mc[m]; end
                end else if (j >= 0 && m_hit[m][j]) begin code = 4; idx = j; end
                else code = 2;
            end else begin
                if (j < 0) code = 2;
                else if (m_hit[m][j]) begin code = 4; idx = j; end
                else if (t_data[j] == wdata) begin m_hit[m][j] = 1; m_mc[m]++; end
                else begin code = 1; idx = j; end
            end
        end
        if (code != 0) begin
            m_run[m] = 0; m_fail[m] = 1; m_code[m] = code; m_idx[m] = idx;
        end else if (m_mc[m] == t_n) begin
            m_run[m] = 0; m_pass[m] = 1;
        end else if (m_cc[m] == int'(TO)) begin
            m_run[m] = 0; m_fail[m] = 1; m_code[m] = 3; m_idx[m] = 0;
        end
    endtask

    // Advance the model by one clock with the current inputs.
    task automatic model_step();
        bit idle;
        idle = !(m_run[1] || m_pass[1] || m_fail[1]);
        if (idle && load_valid && t_n < int'(NC)) begin
            t_addr[t_n] = load_addr; t_data[t_n] = load_data; t_n++;
        end
        for (int m = 0; m < 2; m++) begin
            if (m_run[m]) model_run(m);
            else if (start) model_begin(m);
        end
    endtask

    function automatic logic [44:0] exp_vec(int m);
        return {m_pass[m] | m_fail[m], m_pass[m], m_fail[m], 3'(m_code[m]), 3'(m_idx[m]),
                4'(m_mc[m]), 32'(m_cc[m])};
    endfunction

    function automatic logic [44:0] obs_vec(int m);
        return {dn[m], ps[m], fl[m], fc[m], fi[m], mc[m], cc[m]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(logic [31:0] a, logic [31:0] d);
        load_valid = 1; load_addr = a; load_data = d; tick(); load_valid = 0;
    endtask

    task automatic do_write(logic [31:0] a, logic [31:0] d);
        mem_write = 1; adr = a; wdata = d; tick(); mem_write = 0;
    endtask

    task automatic do_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic hard_reset();
        rst_n = 0; #1;
        model_reset();
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1;
    endtask

    task automatic load_plan();
        load_entry(32'd100, 32'h4585e600);
        load_entry(32'd104, 32'h45c8c700);
        load_entry(32'd108, 32'h00004040);
        load_entry(32'd112, 32'h00003A80);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        hard_reset();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs_vec(m) !== exp_vec(m) || obs_vec(m) !== 45'd0) begin
                failures++; $display("FAIL reset dut=%0d got=%h want=%h", m, obs_vec(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_ordered_pass();
        load_plan();
        do_start();
        do_write(32'd100, 32'h4585e600);
        do_write(32'd104, 32'h45c8c700);
        do_write(32'd108, 32'h00004040);
        checks++;
        if (dn[1] !== 1'b0) begin failures++; $display("FAIL ord_pass_early got done=%b want 0", dn[1]); end
        do_write(32'd112, 32'h00003A80);
        checks++;
        if (ps[1] !== 1'b1 || fc[1] !== 3'd0 || mc[1] !== 4'd4) begin
            failures++; $display("FAIL ord_pass got pass=%b code=%0d mc=%0d want 1/0/4", ps[1], fc[1], mc[1]);
        end
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs_vec(m) !== exp_vec(m)) begin
                failures++; $display("FAIL ord_pass_model dut=%0d got=%h want=%h", m, obs_vec(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_data_mismatch();
        do_start();
        do_write(32'd100, 32'h4585e600);
        do_write(32'd104, 32'h45c8c700);
        do_write(32'd108, 32'h00004041);
        checks++;
        if (fl[1] !== 1'b1 || fc[1] !== 3'd1 || fi[1] !== 3'd2 || mc[1] !== 4'd2) begin
            failures++;
            $display("FAIL data_mismatch got fail=%b code=%0d idx=%0d mc=%0d want 1/1/2/2", fl[1], fc[1], fi[1], mc[1]);
        end
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs_vec(m) !== exp_vec(m)) begin
                failures++; $display("FAIL data_mismatch_model dut=%0d got=%h want=%h", m, obs_vec(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_any_order();
        do_start();
        do_write(32'd112, 32'h00003A80);
        do_write(32'd100, 32'h4585e600);
        do_write(32'd108, 32'h00004040);
        do_write(32'd104, 32'h45c8c700);
        checks++;
        if (ps[0] !== 1'b1 || mc[0] !== 4'd4) begin
            failures++; $display("FAIL any_pass got pass=%b mc=%0d want 1/4", ps[0], mc[0]);
        end
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs_vec(m) !== exp_vec(m)) begin
                failures++; $display("FAIL any_pass_model dut=%0d got=%h want=%h", m, obs_vec(m), exp_vec(m));
            end
        end
        do_start();
        do_write(32'd104, 32'h45c8c700);
        do_write(32'd104, 32'h45c8c700);
        checks++;
        if (fc[0] !== 3'd4 || fi[0] !== 3'd1) begin
            failures++; $display("FAIL dup got code=%0d idx=%0d want 4/1", fc[0], fi[0]);
        end
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs_vec(m) !== exp_vec(m)) begin
                failures++; $display("FAIL dup_model dut=%0d got=%h want=%h", m, obs_vec(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_unexpected_addr();
        do_start();
        do_write(32'd96, 32'h12345678);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (fc[m] !== 3'd2 || fi[m] !== 3'd0 || obs_vec(m) !== exp_vec(m)) begin
                failures++; $display("FAIL bad_addr dut=%0d got=%h want=%h", m, obs_vec(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_timeout();
        do_start();
        repeat (19) tick();
        checks++;
        if (dn !== 2'b00) begin failures++; $display("FAIL timeout_early got done=%b want 00", dn); end
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (fc[m] !== 3'd3 || cc[m] !== 32'd20 || obs_vec(m) !== exp_vec(m)) begin
                failures++; $display("FAIL timeout dut=%0d got=%h want=%h", m, obs_vec(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_write_on_timeout();
        do_start();
        do_write(32'd100, 32'h4585e600);
        do_write(32'd104, 32'h45c8c700);
        do_write(32'd108, 32'h00004040);
        repeat (16) tick();
        do_write(32'd112, 32'h00003A80);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (ps[m] !== 1'b1 || cc[m] !== 32'd20 || obs_vec(m) !== exp_vec(m)) begin
                failures++; $display("FAIL write_on_timeout dut=%0d got=%h want=%h", m, obs_vec(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        hard_reset();
        load_plan();
        do_start();
        do_write(32'd100, 32'h4585e600);
        do_write(32'd104, 32'h45c8c700);
        checks++;
        if (mc[1] !== 4'd2) begin failures++; $display("FAIL mid_run_pre got mc=%0d want 2", mc[1]); end
        rst_n = 0; #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs_vec(m) !== 45'd0 || obs_vec(m) !== exp_vec(m)) begin
                failures++; $display("FAIL mid_run_reset dut=%0d got=%h want=0", m, obs_vec(m));
            end
        end
        hard_reset();
    endtask

    task automatic test_empty_start();
        hard_reset();
        do_start();
        checks++;
        if (dn !== 2'b00) begin failures++; $display("FAIL empty_start_early got done=%b want 00", dn); end
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (ps[m] !== 1'b1 || mc[m] !== 4'd0 || obs_vec(m) !== exp_vec(m)) begin
                failures++; $display("FAIL empty_start dut=%0d got=%h want=%h", m, obs_vec(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_ninth_load();
        hard_reset();
        for (int i = 0; i < 9; i++) load_entry(32'd200 + 32'(4 * i), 32'h1000 + 32'(i));
        do_start();
        for (int i = 0; i < 7; i++) do_write(32'd200 + 32'(4 * i), 32'h1000 + 32'(i));
        checks++;
        if (dn !== 2'b00) begin failures++; $display("FAIL ninth_early got done=%b want 00", dn); end
        do_write(32'd228, 32'h1007);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (ps[m] !== 1'b1 || mc[m] !== 4'd8 || obs_vec(m) !== exp_vec(m)) begin
                failures++; $display("FAIL ninth_load dut=%0d got=%h want=%h", m, obs_vec(m), exp_vec(m));
            end
        end
    endtask

    task automatic test_random();
        int n, k;
        for (int round = 0; round < 6; round++) begin
            hard_reset();
            n = int'($urandom_range(0, 9));
            for (int i = 0; i < n; i++)
                load_entry(32'h40 + 32'(4 * $urandom_range(0, 5)), 32'($urandom_range(0, 65535)));
            do_start();
            for (int c = 0; c < 30; c++) begin
                mem_write = ($urandom_range(0, 1) == 1);
                if (t_n > 0 && $urandom_range(0, 4) != 0) begin
                    k = int'($urandom_range(0, t_n - 1));
                    adr = t_addr[k];
                    wdata = ($urandom_range(0, 6) != 0) ? t_data[k] : (t_data[k] ^ 32'h1);
                end else begin
                    adr = 32'h40 + 32'(4 * $urandom_range(0, 5));
                    wdata = $urandom;
                end
                start = ($urandom_range(0, 15) == 0);
                load_valid = ($urandom_range(0, 7) == 0);
                load_addr = adr; load_data = wdata;
                tick();
                for (int m = 0; m < 2; m++) begin
                    checks++;
                    if (obs_vec(m) !== exp_vec(m)) begin
                        failures++;
                        $display("FAIL random r%0d c%0d dut=%0d got=%h want=%h", round, c, m, obs_vec(m), exp_vec(m));
                    end
                end
            end
            mem_write = 0; start = 0; load_valid = 0;
        end
    endtask

    initial begin
        load_valid = 0; start = 0; mem_write = 0;
        load_addr = '0; load_data = '0; adr = '0; wdata = '0;
        model_reset();
        #3;
        test_reset();
        test_ordered_pass();
        test_data_mismatch();
        test_any_order();
        test_unexpected_addr();
        test_timeout();
        test_write_on_timeout();
        test_reset_mid_run();
        test_empty_start();
        test_ninth_load();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
Parametrised, synthesizable self-checking monitor for the processor's data-memory write port. It replaces hard-coded per-address expected-value checks with a loadable table of N expected (address, data) pairs. It supports in-order or any-order checking, duplicate detection, timeout, and cycle counting. It sits beside the core in sim and FPGA builds, snooping MemWrite/Adr/WriteData, and reports pass/fail with a failure code and the index of the failing entry.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, write-data width
N_CHECKS, 8, expected-table depth (>=1)
TIMEOUT, 4096, RUN cycles allowed before timeout fail (>=1)
ORDERED, 1, 1 = writes must arrive in table order; 0 = any order, each entry at most once

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
load_valid  in  1  append one expected entry
load_addr  in  ADDR_W  expected address
load_data  in  DATA_W  expected data
start  in  1  begin/restart checking
MemWrite  in  1  core memory write strobe
Adr  in  ADDR_W  core write address
WriteData  in  DATA_W  core write data
done  out  1  verdict reached (PASS or FAIL)
pass  out  1  all loaded entries matched
fail  out  1  failure detected
fail_code  out  3  0 none, 1 data mismatch, 2 unexpected address, 3 timeout, 4 duplicate write
fail_idx  out  clog2(N_CHECKS)  entry index involved (0 for codes 2/3)
match_count  out  clog2(N_CHECKS+1)  entries matched so far
cycle_count  out  32  RUN cycles elapsed, frozen at verdict

Behaviour:
- Reset (reset=0, async): state IDLE; table, hit mask, load pointer, all outputs = 0.
- States: IDLE, RUN, PASS, FAIL. done = (PASS|FAIL); pass = PASS; fail = FAIL. All outputs are registered.
- IDLE: load_valid writes entry[load_ptr] and increments load_ptr. Loads at load_ptr==N_CHECKS are dropped and the pointer saturates. start -> RUN; clears hits, match_count, cycle_count.
- RUN: cycle_count increments every cycle. A write is sampled when MemWrite=1 at the rising edge.
  - ORDERED=1: compare against entry[match_count]. Address and data equal -> hit, match_count+1. Address equal, data differs -> FAIL code 1, fail_idx=match_count. Address equal to some other loaded entry -> FAIL code 4 if that entry is already hit, else code 2. No address match -> FAIL code 2.
  - ORDERED=0: parallel address compare over loaded entries; the lowest matching index wins. Matched but not yet hit: data equal -> set hit, +1; data differs -> FAIL code 1. Matched and already hit -> FAIL code 4. No match -> FAIL code 2.
  - match_count reaching load_ptr -> PASS, visible on the cycle after the completing write.
  - cycle_count reaching TIMEOUT without a verdict -> FAIL code 3.
- Simultaneous write and timeout in the same cycle: the write is evaluated first. If it completes the set -> PASS; if it fails -> its own code; otherwise -> timeout.
- start asserted with load_ptr==0 -> PASS one cycle later.
- PASS/FAIL are sticky. Loads are ignored. start -> RUN with the table retained, and hits/counters/fail fields cleared. start and load_valid are ignored while in RUN.
- Writes in IDLE, PASS and FAIL are ignored.
- Reset asserted mid-RUN aborts immediately to IDLE with the table cleared.

Decomposition:
- Package mwc_pkg: state enum (IDLE, RUN, PASS, FAIL) and fail-code constants (FC_NONE, FC_DATA, FC_ADDR, FC_TIMEOUT, FC_DUP).
- Sub-module mwc_match: combinational N-way address compare plus priority encoder. Outputs any_match, match_idx and data_eq.

Test Plan:
- ORDERED=1: load (100,4585e600), (104,45c8c700), (108,00004040), (112,00003A80); start; apply the four writes in order -> pass=1, fail_code=0, match_count=4, on the cycle after the 112 write.
- Same table; write 108 with data 00004041 as the third write -> fail=1, fail_code=1, fail_idx=2, match_count=2.
- ORDERED=0, same table: writes in order 112, 100, 108, 104 -> pass; then restart with start, write 104 twice -> fail_code=4, fail_idx=1.
- Any mode: write to address 96 -> fail_code=2, fail_idx=0.
- TIMEOUT=20, no writes -> fail_code=3 with cycle_count=20. Also: completing write on the timeout cycle -> pass.
- Assert reset=0 mid-RUN after 2 matches -> all outputs 0 at once. Start with empty table -> pass next cycle. A 9th load with N_CHECKS=8 is dropped.
